seq_pattern_timer: RTL and testbench

- Parametrised successor to the fixed 1101 start-sequence detector.
- Searches a serial bit stream for a runtime-programmable PAT_W-bit pattern, with overlapping matches allowed.
- On a match it drives a shift-enable window of SHIFT_LEN cycles, then waits for an external counter to finish, then holds done until acknowledged, then re-arms.
- Sits between the serial command input and the shift/count datapath of the timer subsystem.

---
 rtl/seq_timer_pkg.sv | 20 ++
 rtl/seq_pattern_match.sv | 43 ++++
 rtl/seq_pattern_timer.sv | 98 +++++++++
 tb/tb_seq_pattern_timer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_timer_pkg.sv
// ============================================================================
// seq_timer_pkg : shared state encoding and default pattern for seq_pattern_timer
// Rev 1.0
// ============================================================================
`default_nettype none

package seq_timer_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SHIFT  = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1101;

endpackage

`default_nettype wire

// File: rtl/seq_pattern_match.sv
// ============================================================================
// seq_pattern_match : serial history register, fill counter and pattern compare
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_pattern_match #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  always_comb begin
    hist_d = {hist_q[PAT_W-2:0], data};
    fill_d = (fill_q == FILL_W'(PAT_W)) ? fill_q : fill_q + 1'b1;
    // Compare against the history as it will be after this bit is taken.
    hit    = data_valid && (fill_q >= FILL_W'(PAT_W - 1)) && (hist_d == pattern);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (data_valid) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_pattern_timer.sv
// ============================================================================
// seq_pattern_timer : pattern search, shift window, external count wait, done/ack
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_pattern_timer
  import seq_timer_pkg::*;
#(
  parameter int PAT_W     = 4,
  parameter int SHIFT_LEN = 4,
  parameter bit AUTO_ACK  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             data_valid,
  input  logic             data,
  input  logic [PAT_W-1:0] pattern,
  input  logic             cnt_done,
  input  logic             ack,
  output logic             match,
  output logic             shift_ena,
  output logic             counting,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam int CNT_W = $clog2(SHIFT_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SHIFT_LEN - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  logic             search_valid;
  logic             hist_clear;

  // History only advances while searching; leaving DONE starts a fresh pattern.
  assign search_valid = data_valid && (state_q == SEARCH);
  assign hist_clear   = (state_q == DONE) && (AUTO_ACK || ack);

  seq_pattern_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk        (clk),
    .reset      (reset),
    .clear      (hist_clear),
    .data_valid (search_valid),
    .data       (data),
    .pattern    (pattern),
    .hit        (hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEARCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        if (hit) begin
          state_d = SHIFT;
          cnt_d   = CNT_LOAD;
        end
      end
      SHIFT: begin
        if (cnt_q == '0) state_d = WAIT;
        else             cnt_d   = cnt_q - 1'b1;
      end
      WAIT: begin
        if (cnt_done) state_d = DONE;
      end
      DONE: begin
        if (AUTO_ACK || ack) state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase
  end

  // The counter still holds its load value only in the first SHIFT cycle.
  always_comb begin
    match     = (state_q == SHIFT) && (cnt_q == CNT_LOAD);
    shift_ena = (state_q == SHIFT);
    counting  = (state_q == WAIT);
    done      = (state_q == DONE);
    state_o   = state_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_timer.sv
// ============================================================================
// tb_seq_pattern_timer : directed self-checking bench for seq_pattern_timer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seq_pattern_timer;
  import seq_timer_pkg::*;

  // Observation vector layout: {match, shift_ena, counting, done, state_o}
  localparam logic [5:0] O_IDLE  = 6'b000000;
  localparam logic [5:0] O_SH1   = 6'b110001;
  localparam logic [5:0] O_SHN   = 6'b010001;
  localparam logic [5:0] O_WAIT  = 6'b001010;
  localparam logic [5:0] O_DONE  = 6'b000111;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // dut0: defaults
  logic       rst0 = 1'b1, dv0 = 1'b0, d0 = 1'b0, cd0 = 1'b0, ak0 = 1'b0;
  logic [3:0] pat0 = DEFAULT_PATTERN;
  logic       m0, se0, cn0, dn0;
  logic [1:0] st0;
  logic [5:0] obs0;
  assign obs0 = {m0, se0, cn0, dn0, st0};

  // dut1: PAT_W=6, SHIFT_LEN=8
  logic       rst1 = 1'b1, dv1 = 1'b0, d1 = 1'b0, cd1 = 1'b0, ak1 = 1'b0;
  logic [5:0] pat1 = 6'b101010;
  logic       m1, se1, cn1, dn1;
  logic [1:0] st1;
  logic [5:0] obs1;
  assign obs1 = {m1, se1, cn1, dn1, st1};

  // dut2: AUTO_ACK=1, SHIFT_LEN=1
  logic       rst2 = 1'b1, dv2 = 1'b0, d2 = 1'b0, cd2 = 1'b0, ak2 = 1'b0;
  logic [3:0] pat2 = DEFAULT_PATTERN;
  logic       m2, se2, cn2, dn2;
  logic [1:0] st2;
  logic [5:0] obs2;
  assign obs2 = {m2, se2, cn2, dn2, st2};

  seq_pattern_timer #(.PAT_W(4), .SHIFT_LEN(4), .AUTO_ACK(1'b0)) dut0 (
    .clk(clk), .reset(rst0), .data_valid(dv0), .data(d0), .pattern(pat0),
    .cnt_done(cd0), .ack(ak0), .match(m0), .shift_ena(se0), .counting(cn0),
    .done(dn0), .state_o(st0)
  );

  seq_pattern_timer #(.PAT_W(6), .SHIFT_LEN(8), .AUTO_ACK(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .data_valid(dv1), .data(d1), .pattern(pat1),
    .cnt_done(cd1), .ack(ak1), .match(m1), .shift_ena(se1), .counting(cn1),
    .done(dn1), .state_o(st1)
  );

  seq_pattern_timer #(.PAT_W(4), .SHIFT_LEN(1), .AUTO_ACK(1'b1)) dut2 (
    .clk(clk), .reset(rst2), .data_valid(dv2), .data(d2), .pattern(pat2),
    .cnt_done(cd2), .ack(ak2), .match(m2), .shift_ena(se2), .counting(cn2),
    .done(dn2), .state_o(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send0(input logic b);
    dv0 = 1'b1; d0 = b; tick(); dv0 = 1'b0;
  endtask

  task automatic send1(input logic b);
    dv1 = 1'b1; d1 = b; tick(); dv1 = 1'b0;
  endtask

  task automatic send2(input logic b);
    dv2 = 1'b1; d2 = b; tick(); dv2 = 1'b0;
  endtask

  // From the first SHIFT cycle: finish the window, complete the count, acknowledge.
  task automatic release0(input int shift_left);
    for (int i = 0; i < shift_left; i++) tick();
    cd0 = 1'b1; tick(); cd0 = 1'b0;
    ak0 = 1'b1; tick(); ak0 = 1'b0;
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    tick(); tick();
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    chk_cnt++; if (obs0 !== O_IDLE) $display("FAIL reset dut0: got %b expected %b", obs0, O_IDLE); else pass_cnt++;
    chk_cnt++; if (obs1 !== O_IDLE) $display("FAIL reset dut1: got %b expected %b", obs1, O_IDLE); else pass_cnt++;
    chk_cnt++; if (obs2 !== O_IDLE) $display("FAIL reset dut2: got %b expected %b", obs2, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [4:0] v = 5'b01101;
    logic [5:0] exp;
    for (int i = 4; i >= 0; i--) begin
      send0(v[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL basic bit%0d: got %b expected %b", 4 - i, obs0, exp); else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (obs0 !== O_SHN) $display("FAIL basic shift%0d: got %b expected %b", i + 2, obs0, O_SHN); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (obs0 !== O_WAIT) $display("FAIL basic wait: got %b expected %b", obs0, O_WAIT); else pass_cnt++;
    tick();
    chk_cnt++; if (obs0 !== O_WAIT) $display("FAIL basic wait_hold: got %b expected %b", obs0, O_WAIT); else pass_cnt++;
    cd0 = 1'b1; tick(); cd0 = 1'b0;
    chk_cnt++; if (obs0 !== O_DONE) $display("FAIL basic done: got %b expected %b", obs0, O_DONE); else pass_cnt++;
    tick();
    chk_cnt++; if (obs0 !== O_DONE) $display("FAIL basic done_hold: got %b expected %b", obs0, O_DONE); else pass_cnt++;
    ak0 = 1'b1; tick(); ak0 = 1'b0;
    chk_cnt++; if (obs0 !== O_IDLE) $display("FAIL basic ack: got %b expected %b", obs0, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_lead_ones();
    logic [4:0] v = 5'b11101;
    logic [5:0] exp;
    for (int i = 4; i >= 0; i--) begin
      send0(v[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL lead_ones bit%0d: got %b expected %b", 4 - i, obs0, exp); else pass_cnt++;
    end
    release0(4);
  endtask

  task automatic test_late_match();
    logic [7:0] v = 8'b11001101;
    logic [5:0] exp;
    for (int i = 7; i >= 0; i--) begin
      send0(v[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL late_match bit%0d: got %b expected %b", 7 - i, obs0, exp); else pass_cnt++;
    end
    release0(4);
  endtask

  task automatic test_gaps_ack();
    logic [5:0] vv = 6'b101011;   // valid flags, first bit at MSB
    logic [5:0] vd = 6'b101101;   // data (1,x,1,x,0,1) with junk in the gaps
    logic [5:0] fresh = 6'b101101;
    logic [5:0] exp;
    for (int i = 5; i >= 0; i--) begin
      dv0 = vv[i]; d0 = vd[i]; tick(); dv0 = 1'b0;
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL gaps step%0d: got %b expected %b", 5 - i, obs0, exp); else pass_cnt++;
    end
    for (int i = 0; i < 4; i++) tick();
    chk_cnt++; if (obs0 !== O_WAIT) $display("FAIL gaps wait: got %b expected %b", obs0, O_WAIT); else pass_cnt++;
    cd0 = 1'b1; ak0 = 1'b1; tick(); cd0 = 1'b0;
    chk_cnt++; if (obs0 !== O_DONE) $display("FAIL cd_ack_together: got %b expected %b", obs0, O_DONE); else pass_cnt++;
    tick(); ak0 = 1'b0;
    chk_cnt++; if (obs0 !== O_IDLE) $display("FAIL gaps ack: got %b expected %b", obs0, O_IDLE); else pass_cnt++;
    // Stale history would match on the 3rd bit; a cleared one only on the 6th.
    for (int i = 5; i >= 0; i--) begin
      send0(fresh[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL fresh bit%0d: got %b expected %b", 5 - i, obs0, exp); else pass_cnt++;
    end
    release0(4);
  endtask

  task automatic test_pat6();
    logic [2:0] a = 3'b101;
    logic [2:0] b = 3'b010;
    logic [5:0] exp;
    // History 000101 equals this pattern after 3 bits, but the fill is short.
    pat1 = 6'b000101;
    for (int i = 2; i >= 0; i--) begin
      send1(a[i]);
      chk_cnt++; if (obs1 !== O_IDLE) $display("FAIL pat6 short bit%0d: got %b expected %b", 2 - i, obs1, O_IDLE); else pass_cnt++;
    end
    pat1 = 6'b101010;
    for (int i = 2; i >= 0; i--) begin
      send1(b[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs1 !== exp) $display("FAIL pat6 bit%0d: got %b expected %b", 5 - i, obs1, exp); else pass_cnt++;
    end
    for (int i = 0; i < 7; i++) begin
      tick();
      chk_cnt++; if (obs1 !== O_SHN) $display("FAIL pat6 shift%0d: got %b expected %b", i + 2, obs1, O_SHN); else pass_cnt++;
    end
    tick();
    chk_cnt++; if (obs1 !== O_WAIT) $display("FAIL pat6 wait: got %b expected %b", obs1, O_WAIT); else pass_cnt++;
    cd1 = 1'b1; tick(); cd1 = 1'b0;
    chk_cnt++; if (obs1 !== O_DONE) $display("FAIL pat6 done: got %b expected %b", obs1, O_DONE); else pass_cnt++;
    ak1 = 1'b1; tick(); ak1 = 1'b0;
    chk_cnt++; if (obs1 !== O_IDLE) $display("FAIL pat6 ack: got %b expected %b", obs1, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_auto_ack();
    logic [3:0] v = 4'b1101;
    for (int i = 3; i >= 0; i--) send2(v[i]);
    chk_cnt++; if (obs2 !== O_SH1) $display("FAIL auto match: got %b expected %b", obs2, O_SH1); else pass_cnt++;
    tick();
    chk_cnt++; if (obs2 !== O_WAIT) $display("FAIL auto single_shift: got %b expected %b", obs2, O_WAIT); else pass_cnt++;
    tick();
    chk_cnt++; if (obs2 !== O_WAIT) $display("FAIL auto wait_hold: got %b expected %b", obs2, O_WAIT); else pass_cnt++;
    cd2 = 1'b1; tick(); cd2 = 1'b0;
    chk_cnt++; if (obs2 !== O_DONE) $display("FAIL auto done: got %b expected %b", obs2, O_DONE); else pass_cnt++;
    tick();
    chk_cnt++; if (obs2 !== O_IDLE) $display("FAIL auto return: got %b expected %b", obs2, O_IDLE); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [3:0] v = 4'b1101;
    logic [5:0] exp;
    for (int i = 3; i >= 0; i--) send0(v[i]);
    tick(); tick();
    chk_cnt++; if (obs0 !== O_SHN) $display("FAIL midrst shift3: got %b expected %b", obs0, O_SHN); else pass_cnt++;
    rst0 = 1'b1; tick(); rst0 = 1'b0;
    chk_cnt++; if (obs0 !== O_IDLE) $display("FAIL midrst cleared: got %b expected %b", obs0, O_IDLE); else pass_cnt++;
    for (int i = 3; i >= 0; i--) begin
      send0(v[i]);
      exp = (i == 0) ? O_SH1 : O_IDLE;
      chk_cnt++; if (obs0 !== exp) $display("FAIL midrst rematch bit%0d: got %b expected %b", 3 - i, obs0, exp); else pass_cnt++;
    end
    release0(4);
    chk_cnt++; if (obs0 !== O_IDLE) $display("FAIL midrst end: got %b expected %b", obs0, O_IDLE); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lead_ones();
    test_late_match();
    test_gaps_ack();
    test_pat6();
    test_auto_ack();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
